// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chip8_pkg
//  Purpose  : Shared definitions for the Chip-8 PS/2 keypad receiver:
//             scan-code prefix bytes, deframer state encoding and the
//             set-2 scan code to hex-key lookup.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package chip8_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Returns {valid, key[3:0]}; valid=0 for codes outside the keypad area.
    function automatic logic [4:0] scancode_to_key(input logic [7:0] code);
        logic [4:0] r;
        case (code)
            8'h16:   r = {1'b1, 4'h1};
            8'h1E:   r = {1'b1, 4'h2};
            8'h26:   r = {1'b1, 4'h3};
            8'h25:   r = {1'b1, 4'hC};
            8'h15:   r = {1'b1, 4'h4};
            8'h1D:   r = {1'b1, 4'h5};
            8'h24:   r = {1'b1, 4'h6};
            8'h2D:   r = {1'b1, 4'hD};
            8'h1C:   r = {1'b1, 4'h7};
            8'h1B:   r = {1'b1, 4'h8};
            8'h23:   r = {1'b1, 4'h9};
            8'h2B:   r = {1'b1, 4'hE};
            8'h1A:   r = {1'b1, 4'hA};
            8'h22:   r = {1'b1, 4'h0};
            8'h21:   r = {1'b1, 4'hB};
            8'h2A:   r = {1'b1, 4'hF};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

endpackage : chip8_pkg
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx_frame
//  Purpose  : Synchronises the PS/2 clock/data pair, detects falling edges of
//             ps2_clk and deframes 11-bit frames (start, 8 data LSB first,
//             odd parity, stop). Partial frames are dropped after TIMEOUT
//             clk cycles without an edge.
//  Ports    : clk_i, res_i          - system clock, async active-high reset
//             ps2_clk_i, ps2_data_i - asynchronous PS/2 lines (idle high)
//             byte_o, byte_valid_o  - received byte, one-cycle valid pulse
//             frame_err_o           - one-cycle pulse on any frame error
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_frame
    import chip8_pkg::*;
#(
    parameter int TIMEOUT     = 16384,
    parameter int SYNC_STAGES = 2        // must be >= 2
) (
    input  logic       clk_i,
    input  logic       res_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;

    ps2_state_e             state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             byte_q;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic                   ps2_clk_s;
    logic                   ps2_bit;
    logic                   fall;
    logic                   timeout_hit;

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_bit   = data_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q & ~ps2_clk_s;

    // An edge in the same cycle always beats the timeout.
    assign timeout_hit = (state_q != ST_IDLE) && !fall &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register (also holds the synchronisers and registered outputs)
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bitcnt_q     <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            cnt_q        <= '0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q   <= ps2_clk_s;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            cnt_q        <= cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            if (byte_valid_d) begin
                byte_q <= shift_q;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        cnt_d    = cnt_q + CNT_W'(1);
        if (fall) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!ps2_bit) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {ps2_bit, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = ps2_bit;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (timeout_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Output logic (registered one cycle later in the state register)
    always_comb begin
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall) begin
            if (state_q == ST_IDLE && ps2_bit) begin
                frame_err_d = 1'b1;
            end else if (state_q == ST_STOP) begin
                if (ps2_bit && (^{shift_q, parity_q})) begin
                    byte_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end else if (timeout_hit) begin
            frame_err_d = 1'b1;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule : ps2_rx_frame
`default_nettype wire

// File: rtl/ps2_keypad.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keypad
//  Purpose  : PS/2 keyboard receiver for the Chip-8 hex keypad. Decodes set-2
//             make/break codes into a 16-bit key state and emits one event
//             per actual key change.
//  Ports    : clk, res            - system clock, async active-high reset
//             ps2_clk, ps2_data   - PS/2 lines from user_io
//             keys                - live keypad state, bit n = key n held
//             key_event           - one-cycle pulse on any keys change
//             key_code, key_down  - index and direction of the last event
//             frame_err           - one-cycle pulse on a frame error
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_keypad
    import chip8_pkg::*;
#(
    parameter int TIMEOUT     = 16384,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keys,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic        frame_err
);

    logic [7:0]  rx_byte;
    logic        rx_valid;

    logic [15:0] keys_q, keys_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic        event_q, event_d;
    logic [3:0]  code_q, code_d;
    logic        down_q, down_d;

    logic [4:0]  lookup;
    logic [3:0]  k;
    logic        new_val;

    ps2_rx_frame #(
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk_i        (clk),
        .res_i        (res),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (frame_err)
    );

    assign lookup  = scancode_to_key(rx_byte);
    assign k       = lookup[3:0];
    assign new_val = ~brk_q;

    always_comb begin
        keys_d  = keys_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        event_d = 1'b0;
        code_d  = code_q;
        down_d  = down_q;
        if (rx_valid) begin
            if (rx_byte == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                // Extended codes share base codes with keypad keys; skip them.
                // Typematic repeats leave keys unchanged and stay silent.
                if (!ext_q && lookup[4] && (keys_q[k] != new_val)) begin
                    keys_d[k] = new_val;
                    event_d   = 1'b1;
                    code_d    = k;
                    down_d    = new_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            keys_q  <= 16'd0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            event_q <= 1'b0;
            code_q  <= 4'd0;
            down_q  <= 1'b0;
        end else begin
            keys_q  <= keys_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            event_q <= event_d;
            code_q  <= code_d;
            down_q  <= down_d;
        end
    end

    assign keys      = keys_q;
    assign key_event = event_q;
    assign key_code  = code_q;
    assign key_down  = down_q;

endmodule : ps2_keypad
`default_nettype wire

// File: doc/ps2_keypad.md
Name: ps2_keypad

Overview:
- PS/2 device-to-host receiver for the Chip-8 machine.
- Consumes the ps2_clk/ps2_data pair that the user_io block drives.
- Deframes 11-bit PS/2 frames and decodes set-2 make/break scan codes.
- Maintains the live state of the 16-key Chip-8 hex keypad and emits one event pulse per key change, for the CPU's key-wait and key-skip opcodes.

Parameters:
- TIMEOUT, 16384: clk cycles without a ps2_clk falling edge before a partial frame is discarded.
- SYNC_STAGES, 2: synchroniser depth for ps2_clk and ps2_data.

Ports:
- clk  input  1  system clock (clk_25M domain); ps2 lines are asynchronous to it.
- res  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  PS/2 clock from user_io, idle high.
- ps2_data  input  1  PS/2 data from user_io, idle high.
- keys  output  16  current keypad state; bit n = Chip-8 key n held.
- key_event  output  1  one-cycle pulse on any keys bit change.
- key_code  output  4  Chip-8 key index of the last event; valid while key_event is high, held afterwards.
- key_down  output  1  1 = press, 0 = release, for the last event.
- frame_err  output  1  one-cycle pulse on a start, stop, parity or timeout error.

Behaviour:
- Reset values: keys=0, key_event=0, key_code=0, key_down=0, frame_err=0, FSM=IDLE, break and extended flags cleared. Reset asserted mid-frame aborts the frame with no error pulse.
- Synchronisation and sampling:
  - Both lines pass through SYNC_STAGES flops.
  - A falling edge is synced ps2_clk going 1->0 between consecutive clk cycles.
  - ps2_data is sampled on the cycle that edge is detected.
- Frame deframer FSM:
  - IDLE: on a falling edge with data=0, go to DATA with bitcnt=0. A falling edge with data=1 pulses frame_err and stays in IDLE.
  - DATA: shift in data LSB first on each edge. After the 8th bit, go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: capture the bit. If stop=1 and XOR(data, parity)=1 (odd parity), the byte is valid. Otherwise pulse frame_err. Either way return to IDLE.
  - Timeout counter clears on every falling edge. In any state other than IDLE, reaching TIMEOUT pulses frame_err and returns to IDLE.
- Byte decoder, acting on each valid byte the cycle after STOP:
  - 0xE0: set the extended flag.
  - 0xF0: set the break flag.
  - Any other byte:
    - If extended=0 and the code is mapped, compute the key index k. Press sets keys[k], release clears it.
    - Pulse key_event, load key_code=k, load key_down=!break, but only if keys[k] actually changes. Typematic repeats of a held key produce no event.
    - Clear both flags after any non-prefix byte, mapped or not.
- Scan-code map (set 2 -> Chip-8 key):
  - 16->1, 1E->2, 26->3, 25->C
  - 15->4, 1D->5, 24->6, 2D->D
  - 1C->7, 1B->8, 23->9, 2B->E
  - 1A->A, 22->0, 21->B, 2A->F
  - All other codes are ignored.
- Latency: key_event asserts exactly 2 clk cycles after the cycle in which the stop-bit edge is detected (1 cycle deframe register, 1 cycle decode).
- Simultaneous events:
  - A timeout and a falling edge in the same cycle: the edge wins and the timeout counter clears.
  - Only one byte completes per frame, so decoder events never collide.

Decomposition:
- Shared package chip8_pkg: PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, the FSM state encoding, and a keymap function scancode_to_key returning {valid, key[3:0]}.
- One sub-module, ps2_rx_frame: synchroniser, edge detect, deframer FSM and timeout. Outputs byte[7:0], byte_valid and frame_err.
- Top-level ps2_keypad: prefix flags, keymap lookup and the keys register.

Test Plan:
- Send a valid frame for 0x1D (parity bit 1), hold the line for 10 cycles -> keys=16'h0020, key_event for 1 cycle, key_code=5, key_down=1.
- Send 0xF0 then 0x1D -> keys=16'h0000, key_event with key_code=5, key_down=0. The 0xF0 byte alone produces no event.
- Send 0x22 three times (typematic) -> exactly one key_event (key_code=0). keys[0]=1 throughout.
- Send 0xE0 then 0x1A -> no key_event, keys unchanged. A following plain 0x1A -> keys[10]=1.
- Send 0x16 with a wrong parity bit, then a frame with stop=0 -> two frame_err pulses, keys unchanged.
- Send 5 bits of a frame, then stall for TIMEOUT cycles -> frame_err pulse. The next full frame 0x2A is then accepted with keys[15]=1.
- Assert res mid-frame with keys=16'h0003 -> all outputs 0 immediately, no frame_err. The next frame decodes normally.
